// File: rtl/bcd_adder_2digit.sv
// Registered two-digit BCD adder with a carry-in, producing a hundreds bit plus
// tens and units digits one cycle after in_valid. err flags non-BCD input digits.
module bcd_adder_2digit (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] a1,
    input  logic [3:0] a0,
    input  logic [3:0] b1,
    input  logic [3:0] b0,
    input  logic       cin,
    output logic       bcd2,
    output logic [3:0] bcd1,
    output logic [3:0] bcd0,
    output logic       out_valid,
    output logic       err
);

    logic [4:0] s0, s1;
    logic [4:0] s0_adj, s1_adj;
    logic       c0;

    logic       bcd2_d, bcd2_q;
    logic [3:0] bcd1_d, bcd1_q;
    logic [3:0] bcd0_d, bcd0_q;
    logic       out_valid_d, out_valid_q;
    logic       err_d, err_q;

    always_comb begin
        // Sums are at most 31, so 5 bits hold them. The +6 correction may wrap
        // past 31, but only the low nibble of the corrected sum is kept.
        s0     = {1'b0, a0} + {1'b0, b0} + {4'd0, cin};
        s0_adj = s0 + 5'd6;
        c0     = (s0 > 5'd9);

        s1     = {1'b0, a1} + {1'b0, b1} + {4'd0, c0};
        s1_adj = s1 + 5'd6;

        bcd2_d      = bcd2_q;
        bcd1_d      = bcd1_q;
        bcd0_d      = bcd0_q;
        err_d       = err_q;
        out_valid_d = 1'b0;

        if (in_valid) begin
            bcd0_d      = c0 ? s0_adj[3:0] : s0[3:0];
            bcd2_d      = (s1 > 5'd9);
            bcd1_d      = bcd2_d ? s1_adj[3:0] : s1[3:0];
            err_d       = (a1 > 4'd9) | (a0 > 4'd9) | (b1 > 4'd9) | (b0 > 4'd9);
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd2_q      <= 1'b0;
            bcd1_q      <= 4'd0;
            bcd0_q      <= 4'd0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            bcd2_q      <= bcd2_d;
            bcd1_q      <= bcd1_d;
            bcd0_q      <= bcd0_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign bcd2      = bcd2_q;
    assign bcd1      = bcd1_q;
    assign bcd0      = bcd0_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bcd_adder_2digit.sv
// Directed-vector bench for bcd_adder_2digit: table of hand-computed results,
// hold/reset sequences, and a back-to-back stream checked against a decimal model.
module tb_bcd_adder_2digit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] a1, a0, b1, b0;
    logic       cin;
    logic       bcd2;
    logic [3:0] bcd1, bcd0;
    logic       out_valid, err;

    int tests = 0;
    int fails = 0;

    bcd_adder_2digit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .a1(a1), .a0(a0), .b1(b1), .b0(b0), .cin(cin),
        .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
        .out_valid(out_valid), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a1, a0, b1, b0;
        logic       cin;
        logic       e2;
        logic [3:0] e1, e0;
        logic       eerr;
        string      name;
    } vec_t;

    vec_t vecs[$];

    // Packed view: {bcd2, bcd1, bcd0, out_valid, err}
    function automatic logic [10:0] pk(logic h, logic [3:0] t, logic [3:0] u, logic v, logic e);
        return {h, t, u, v, e};
    endfunction

    task automatic check(string name, logic [10:0] exp);
        logic [10:0] act;
        act = pk(bcd2, bcd1, bcd0, out_valid, err);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got bcd2=%0d bcd1=%0d bcd0=%0d ov=%0d err=%0d, want bcd2=%0d bcd1=%0d bcd0=%0d ov=%0d err=%0d",
                     name, act[10], act[9:6], act[5:2], act[1], act[0],
                     exp[10], exp[9:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    task automatic drive(logic [3:0] x1, logic [3:0] x0, logic [3:0] y1, logic [3:0] y0, logic c);
        a1 = x1; a0 = x0; b1 = y1; b0 = y0; cin = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void add_vec(logic [3:0] x1, logic [3:0] x0, logic [3:0] y1, logic [3:0] y0,
                                    logic c, logic h, logic [3:0] t, logic [3:0] u, logic e, string n);
        vec_t v;
        v.a1 = x1; v.a0 = x0; v.b1 = y1; v.b0 = y0; v.cin = c;
        v.e2 = h; v.e1 = t; v.e0 = u; v.eerr = e; v.name = n;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [3:0] r1[10], r0[10], q1[10], q0[10];
        logic       rc[10];
        int         sum;

        add_vec(4, 2, 5, 9, 1,   1, 0, 2, 0, "nominal_42+59+1");
        add_vec(9, 9, 9, 9, 1,   1, 9, 9, 0, "max_99+99+1");
        add_vec(0, 0, 0, 0, 0,   0, 0, 0, 0, "min_0");
        add_vec(4, 5, 5, 4, 1,   1, 0, 0, 0, "carry_45+54+1");
        add_vec(4, 5, 5, 4, 0,   0, 9, 9, 0, "nocarry_45+54");
        add_vec(0, 15, 0, 15, 1, 0, 1, 5, 1, "invalid_units_15+15+1");
        add_vec(1, 2, 3, 4, 0,   0, 4, 6, 0, "valid_after_err_12+34");
        add_vec(10, 0, 0, 0, 0,  1, 0, 0, 1, "invalid_tens_a1=10");
        add_vec(0, 9, 0, 1, 0,   0, 1, 0, 0, "unit_carry_09+01");
        add_vec(5, 0, 5, 0, 0,   1, 0, 0, 0, "tens_carry_50+50");

        // Reset with in_valid high and invalid operands: reset must win.
        rst = 1'b1; in_valid = 1'b1;
        drive(15, 15, 15, 15, 1);
        tick(); check("reset_cycle1", pk(0, 0, 0, 0, 0));
        tick(); check("reset_cycle2", pk(0, 0, 0, 0, 0));
        rst = 1'b0; in_valid = 1'b0;
        tick(); check("idle_after_reset", pk(0, 0, 0, 0, 0));

        // Each vector: one capture cycle, then one hold cycle with scrambled operands.
        foreach (vecs[i]) begin
            drive(vecs[i].a1, vecs[i].a0, vecs[i].b1, vecs[i].b0, vecs[i].cin);
            in_valid = 1'b1;
            tick();
            check(vecs[i].name, pk(vecs[i].e2, vecs[i].e1, vecs[i].e0, 1'b1, vecs[i].eerr));
            in_valid = 1'b0;
            drive(7, 3, 15, 2, ~vecs[i].cin);
            tick();
            check({vecs[i].name, "_hold"}, pk(vecs[i].e2, vecs[i].e1, vecs[i].e0, 1'b0, vecs[i].eerr));
        end

        // Back-to-back stream of random valid BCD operands, checked against decimal arithmetic.
        for (int i = 0; i < 10; i++) begin
            r1[i] = 4'($urandom_range(0, 9)); r0[i] = 4'($urandom_range(0, 9));
            q1[i] = 4'($urandom_range(0, 9)); q0[i] = 4'($urandom_range(0, 9));
            rc[i] = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(r1[i], r0[i], q1[i], q0[i], rc[i]);
            tick();
            sum = 10 * r1[i] + r0[i] + 10 * q1[i] + q0[i] + rc[i];
            check($sformatf("stream_%0d", i),
                  pk(1'(sum / 100), 4'((sum / 10) % 10), 4'(sum % 10), 1'b1, 1'b0));
        end
        in_valid = 1'b0;
        tick();

        // Capture, then reset on the following edge: result is lost.
        drive(4, 5, 5, 4, 1); in_valid = 1'b1;
        tick(); check("pre_reset_capture", pk(1, 0, 0, 1, 0));
        rst = 1'b1; in_valid = 1'b0;
        tick(); check("reset_after_capture", pk(0, 0, 0, 0, 0));

        // Reset and in_valid together with an invalid digit: reset wins, err stays 0.
        drive(0, 15, 0, 15, 1); in_valid = 1'b1;
        tick(); check("reset_priority", pk(0, 0, 0, 0, 0));
        rst = 1'b0;
        tick(); check("capture_after_reset", pk(0, 1, 5, 1, 1));
        in_valid = 1'b0;
        tick(); check("hold_err", pk(0, 1, 5, 0, 1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_adder_2digit.md
Name: bcd_adder_2digit

Overview:
Registered two-digit BCD adder: adds two 2-digit BCD operands plus a carry-in and produces a 3-digit BCD result (hundreds bit, tens digit, units digit).
Used as an arithmetic leaf in decimal datapaths.
One clock, synchronous active-high reset, single-cycle latency.
A simple valid qualifier and an invalid-digit flag are included.

Parameters:
none (fixed at 2 input digits, 4 bits per digit)

Ports:
clk       input   1  rising-edge clock
rst       input   1  synchronous reset, active-high
in_valid  input   1  operands valid this cycle; capture when high
a1        input   4  operand A tens digit (BCD)
a0        input   4  operand A units digit (BCD)
b1        input   4  operand B tens digit (BCD)
b0        input   4  operand B units digit (BCD)
cin       input   1  carry-in, weight 1
bcd2      output  1  result hundreds digit (0 or 1)
bcd1      output  4  result tens digit
bcd0      output  4  result units digit
out_valid output  1  result registers updated by previous-cycle in_valid
err       output  1  at least one captured input digit was > 9

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: while rst is high at a clock edge, bcd2=0, bcd1=0, bcd0=0, out_valid=0, err=0. Reset has priority over in_valid.
- Capture: on a clock edge with rst=0 and in_valid=1, the registers load the combinational result of the current a1/a0/b1/b0/cin, and out_valid is set to 1.
- Hold: on a clock edge with rst=0 and in_valid=0, bcd2/bcd1/bcd0/err hold their values and out_valid is set to 0.
- Latency: exactly 1 cycle from in_valid sampled high to the result and out_valid=1. Back-to-back in_valid gives one result per cycle, with no bubbles and no backpressure.
- Units digit stage:
  - s0 = a0 + b0 + cin, computed as a 5-bit unsigned sum.
  - If s0 > 9: bcd0 = (s0 + 6)[3:0] and c0 = 1.
  - Otherwise: bcd0 = s0[3:0] and c0 = 0.
- Tens digit stage:
  - s1 = a1 + b1 + c0, computed as a 5-bit unsigned sum.
  - If s1 > 9: bcd1 = (s1 + 6)[3:0] and bcd2 = 1.
  - Otherwise: bcd1 = s1[3:0] and bcd2 = 0.
- Valid-operand result: for valid BCD inputs, {bcd2,bcd1,bcd0} equals the decimal value (10*a1 + a0) + (10*b1 + b0) + cin. The range is 0..199.
- Invalid digits: err is registered as (a1>9)|(a0>9)|(b1>9)|(b0>9) at capture. The result registers still load the deterministic correction output defined above; there is no saturation.
  - Example: a0=b0=15, cin=1 gives s0=31, so bcd0=5 and c0=1.
- Inputs are used only at capture edges. No state is kept between operations other than the output registers.
- If reset is asserted in the cycle after a capture, the pending result is lost: outputs go to 0 and out_valid=0.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 and arbitrary operands -> all outputs 0, out_valid=0, err=0.
- Nominal add: a1=4, a0=2, b1=5, b0=9, cin=1, in_valid=1 for one cycle -> next cycle bcd2=1, bcd1=0, bcd0=2, out_valid=1, err=0. The cycle after that has out_valid=0 with values held.
- Maximum: 99+99+1 (a1=a0=b1=b0=9, cin=1) -> bcd2=1, bcd1=9, bcd0=9. Minimum: all operands 0, cin=0 -> 0,0,0.
- Carry chain: 45+54+1 -> bcd2=1, bcd1=0, bcd0=0. 45+54+0 -> bcd2=0, bcd1=9, bcd0=9.
- Back-to-back stream: 10 consecutive random valid-BCD operands with in_valid=1 -> each result matches the decimal model exactly 1 cycle later, with out_valid held high.
- Invalid input: a0=15, b0=15, cin=1, a1=b1=0 -> err=1, bcd0=5, bcd1=1, bcd2=0. Following a valid capture, err returns to 0.
